// File: rtl/corescore_byte_fifo.sv
// Byte FIFO for the JTAG UART bridge.
// DEPTH = 2**AW entries, read/write pointers carry an extra wrap bit so
// full and empty can be told apart without a separate counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push, pop       enqueue din / dequeue head on the rising edge
//   flush           zero both pointers (takes priority over push/pop)
//   din             byte to enqueue
//   head            byte at the read pointer (valid when !empty)
//   full, empty     occupancy flags
//   count           number of stored bytes, 0..DEPTH
module corescore_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/corescore_jtag_uart_bridge.sv
// Bridge from the corescore byte stream to the alt_jtag_atlantic write port.
// Bytes are buffered in a small FIFO and presented with a registered one-cycle
// write strobe. If nobody drains the JTAG UART for STALL_CYCLES cycles the
// bridge flushes its buffer and discards traffic (DROP) until a message
// boundary arrives while the UART is ready again.
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_tdata/i_tlast/i_tvalid/o_tready   upstream byte stream (o_tready registered)
//   o_r_dat, o_r_val                    registered byte and write strobe to the UART
//   i_r_ena                             UART can accept a byte
//   o_dropping                          high while discarding traffic
//   o_drop_count                        saturating count of discarded bytes
module corescore_jtag_uart_bridge #(
  parameter int AW           = 4,
  parameter int STALL_CYCLES = 1000000,
  parameter int CW           = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [7:0]    i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          o_tready,
  output logic [7:0]    o_r_dat,
  output logic          o_r_val,
  input  logic          i_r_ena,
  output logic          o_dropping,
  output logic [CW-1:0] o_drop_count
);

  localparam logic PASS = 1'b0;
  localparam logic DROP = 1'b1;

  localparam int DEPTH = 2 ** AW;
  localparam int SW    = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam bit STALL_EN = (STALL_CYCLES > 0);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);
  localparam logic [SW-1:0] STALL_LAST = STALL_EN ? SW'(STALL_CYCLES - 1) : '0;
  localparam int SUMW = ((CW > AW + 2) ? CW : AW + 2) + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [AW+1:0] b);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(b);
    if (s > SUMW'(CNT_MAX)) return CNT_MAX;
    return s[CW-1:0];
  endfunction

  logic          state, state_n;
  logic [SW-1:0] stall_cnt, stall_n;
  logic          tready_n, val_n;
  logic [7:0]    dat_n;
  logic [CW-1:0] drop_n;

  logic          push, pop, flush;
  logic [7:0]    head;
  logic          full, empty;
  logic [AW:0]   count, count_after;
  logic          accept;

  corescore_byte_fifo #(.AW(AW)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (i_tdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign accept = i_tvalid & o_tready;

  always_comb begin
    state_n     = state;
    stall_n     = stall_cnt;
    tready_n    = o_tready;
    val_n       = 1'b0;
    dat_n       = o_r_dat;
    drop_n      = o_drop_count;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    count_after = count;

    case (state)
      PASS: begin
        pop  = i_r_ena & ~empty;
        push = accept;
        if (pop) begin
          dat_n = head;
          val_n = 1'b1;
        end
        if (!empty && !i_r_ena) begin
          if (STALL_EN && stall_cnt == STALL_LAST) begin
            // Nobody is draining: flush and count everything buffered,
            // including a beat accepted on this same edge.
            flush    = 1'b1;
            push     = 1'b0;
            state_n  = DROP;
            stall_n  = '0;
            tready_n = 1'b1;
            drop_n   = sat_add(o_drop_count, {1'b0, count} + (AW+2)'(accept));
          end else if (stall_cnt != STALL_MAX) begin
            stall_n = stall_cnt + 1'b1;
          end
        end else begin
          stall_n = '0;
        end
        if (!flush) begin
          count_after = count + (AW+1)'(push) - (AW+1)'(pop);
          tready_n    = (count_after != (AW+1)'(DEPTH));
        end
      end
      default: begin
        tready_n = 1'b1;
        stall_n  = '0;
        if (accept) begin
          drop_n = sat_add(o_drop_count, (AW+2)'(1));
          // Resume only on a message boundary with the UART ready.
          if (i_tlast && i_r_ena) state_n = PASS;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= PASS;
      stall_cnt    <= '0;
      o_tready     <= 1'b0;
      o_r_val      <= 1'b0;
      o_r_dat      <= '0;
      o_drop_count <= '0;
    end else begin
      state        <= state_n;
      stall_cnt    <= stall_n;
      o_tready     <= tready_n;
      o_r_val      <= val_n;
      o_r_dat      <= dat_n;
      o_drop_count <= drop_n;
    end
  end

  assign o_dropping = (state == DROP);

endmodule
